// File: rtl/n2p_rx_if.sv
// n2p_rx_if: processor-side valid/ready byte stream of the NoC receive buffer.
//   proc_data  : byte at buffer head
//   proc_last  : head byte ends its packet
//   proc_valid : a committed byte is available
//   proc_ready : processor accepts the head byte
// master = byte source (n2p_rx), slave = processor.
interface n2p_rx_if;
   logic [7:0] proc_data;
   logic       proc_last;
   logic       proc_valid;
   logic       proc_ready;
   modport master (output proc_data, proc_last, proc_valid, input proc_ready);
   modport slave  (input proc_data, proc_last, proc_valid, output proc_ready);
endinterface

// File: rtl/n2p_rx.sv
// n2p_rx: 9-bit NoC link receiver with a store-and-forward packet buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   link_in    : link symbol (data byte, IDLE 100, SOP 101, EOP 102, else illegal)
//   proc       : first-word fall-through byte stream to the processor
//   pkt_count  : committed packets not yet fully read
//   drop_pulse : packet discarded (overflow or zero length)
//   err_pulse  : protocol error
module n2p_rx #(
   parameter int ADDR_WIDTH = 4,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [8:0]            link_in,
   n2p_rx_if.master              proc,
   output logic [ADDR_WIDTH:0]   pkt_count,
   output logic                  drop_pulse,
   output logic                  err_pulse
);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   typedef enum logic [1:0] {WAIT_SOP, RECV, DROP} state_t;
   state_t              state;
   logic [8:0]          mem [RAM_DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
   logic                pend_valid;
   logic [7:0]          pend_byte;
   logic                is_data, is_idle, is_sop, is_eop, full, rd_en, wr_en, commit;
   assign proc.proc_valid = rd_ptr != commit_ptr;
   assign {proc.proc_last, proc.proc_data} = mem[rd_ptr[ADDR_WIDTH-1:0]];
   always_comb begin
      is_data = !link_in[8];
      is_idle = link_in == 9'h100;
      is_sop  = link_in == 9'h101;
      is_eop  = link_in == 9'h102;
      // occupancy includes uncommitted bytes; a same-cycle read frees space only next cycle
      full    = (wr_ptr - rd_ptr) == DEPTH;
      rd_en   = proc.proc_valid && proc.proc_ready;
      // the pending byte is flushed to the buffer by the next data byte or by EOP
      wr_en   = state == RECV && pend_valid && !full && (is_data || is_eop);
      commit  = wr_en && is_eop;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= WAIT_SOP;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         pend_valid <= 1'b0;
         pend_byte  <= '0;
         pkt_count  <= '0;
         drop_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= '0;
      end else begin
         drop_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         pkt_count <= pkt_count + (ADDR_WIDTH + 1)'(commit) - (ADDR_WIDTH + 1)'(rd_en && proc.proc_last);
         if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {is_eop, pend_byte};
            wr_ptr <= wr_ptr + 1'b1;
         end
         case (state)
            WAIT_SOP: begin
               if (is_sop) begin
                  state      <= RECV;
                  pend_valid <= 1'b0;
               end else if (!is_idle) err_pulse <= 1'b1;
            end
            RECV: begin
               if (is_data) begin
                  if (pend_valid && full) begin
                     wr_ptr     <= commit_ptr;
                     pend_valid <= 1'b0;
                     drop_pulse <= 1'b1;
                     state      <= DROP;
                  end else begin
                     pend_valid <= 1'b1;
                     pend_byte  <= link_in[7:0];
                  end
               end else if (is_eop) begin
                  if (commit) commit_ptr <= wr_ptr + 1'b1;
                  else begin
                     // overflow at the last byte, or an empty packet
                     wr_ptr     <= commit_ptr;
                     drop_pulse <= 1'b1;
                  end
                  pend_valid <= 1'b0;
                  state      <= WAIT_SOP;
               end else if (!is_idle) begin
                  // SOP restarts a new packet in place; illegal codes abandon it
                  wr_ptr     <= commit_ptr;
                  pend_valid <= 1'b0;
                  err_pulse  <= 1'b1;
                  state      <= is_sop ? RECV : WAIT_SOP;
               end
            end
            default: begin
               if (is_eop) state <= WAIT_SOP;
               else if (is_sop) begin
                  state      <= RECV;
                  pend_valid <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule
